fp_align_stage: RTL and testbench
=================================

// Module: fp_align_stage
// PURPOSE
//  Upstream alignment stage of the 32-bit floating-point adder. Unpacks two IEEE-754
//  singles, orders them by magnitude, and right-shifts the smaller significand with
//  sticky. Emits {a, b, cin} for the pipelined 32-bit carry-lookahead adder, with effective
//  subtract done as ~b + 1. Two-stage pipeline with valid/ready backpressure.
// PARAMETERS
//  QNAN          32'h7FC00000  canonical NaN driven on special_val
//  FLUSH_DENORM  0             1: denormal inputs treated as signed zero
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   synchronous reset, active-high
//  in_valid     in   1   input operands valid
//  in_ready     out  1   stage can accept this cycle
//  in_a         in   32  IEEE-754 single operand A
//  in_b         in   32  IEEE-754 single operand B
//  in_sub       in   1   1: compute A-B (B sign inverted before processing)
//  out_valid    out  1   outputs below valid
//  out_ready    in   1   downstream accepts this cycle
//  op_a         out  32  larger-magnitude aligned field -> adder a
//  op_b         out  32  smaller aligned field (inverted if eff_sub) -> adder b
//  op_cin       out  1   adder cin (= eff_sub)
//  res_sign     out  1   result sign
//  res_exp      out  8   result exponent before normalisation (larger operand's)
//  eff_sub      out  1   signs differ after in_sub applied
//  special      out  1   result is special_val; downstream bypasses adder path
//  special_val  out  32  NaN/Inf/zero result when special=1
// BEHAVIOUR
//  - Reset: s1_valid=s2_valid=0; out_valid=0; all data outputs 32'h0/0. Reset mid-operation discards in-flight items.
//  - Handshake: transfer on in_valid&in_ready / out_valid&out_ready.
//    adv2 = ~s2_valid | out_ready; in_ready = ~s1_valid | adv2 (combinational, no input path).
//    Outputs stable while out_valid & ~out_ready. Order preserved. Max 2 items in flight.
//  - Latency 2 cycles accept->out_valid when unstalled; throughput 1/cycle.
//  - S1 (unpack/compare/swap): sb = in_b[31]^in_sub.
//    sig = {hidden, frac}: hidden=1 if exp!=0. Denormal: hidden=0, effective exp=1.
//    Order by 31-bit magnitude {exp,frac}; ties keep A as larger. Register larger/smaller sig, exp, sign, d = expL-expS.
//  - S2 (align/invert): field = {1'b0, sig[23:0], 7'b0}.
//    opL = field_L; opS = field_S >> d, with bit0 |= OR of all shifted-out bits.
//    d>=31 -> opS = 32'h1 if sig_S!=0 else 0.
//    op_b = eff_sub ? ~opS : opS; op_cin = eff_sub; res_exp = expL (raw 8-bit field); res_sign = signL.
//  - Exact cancel (eff_sub & equal magnitudes): res_sign forced 0 (+0).
//  - Specials (S1 detect, S2 output, special=1):
//    any NaN, or +Inf with -Inf after sign fix -> QNAN.
//    single Inf -> that Inf with its effective sign.
//    both zero -> zero, sign = sa&sb.
//    In special cases op_a/op_b/op_cin still driven from the path above; they are don't-care downstream.
// TESTING
//  1. A=3F800000 B=3F800000 sub=0 -> 2 cycles later: op_a=op_b=40000000, cin=0, exp=7F, sign=0, special=0
//  2. A=3F800000 B=3F000000 sub=1 -> op_a=40000000, op_b=DFFFFFFF, cin=1, eff_sub=1, exp=7F, sign=0
//  3. A=3F000000 B=40000000 sub=0 -> swap: op_a=40000000, op_b=10000000, exp=80; A=3F800000 B=00800000 -> op_b=00000001 (sticky only)
//  4. A=3F800000 B=BF800000 -> op_b=BFFFFFFF, cin=1, res_sign=0; A=7F800000 B=FF800000 -> special=1, special_val=7FC00000
//  5. A=7F800000 B=3F800000 -> special_val=7F800000. A=7FC00001 -> 7FC00000. A=80000000 B=80000000 -> 80000000
//  6. out_ready=0, issue 3 back-to-back: 2 accepted, then in_ready=0, outputs frozen.
//     out_ready=1 -> drains in order. rst pulse mid-stream -> out_valid=0 next cycle, in_ready=1.

Source files
------------

// File: rtl/fp_align_stage.sv
// fp_align_stage: unpack, magnitude-order and align two IEEE-754 singles so the
// downstream carry-lookahead adder sees {a, b, cin}. Effective subtraction is
// presented as ~b with cin=1. Two registered stages with valid/ready flow control.
module fp_align_stage #(
    parameter logic [31:0] QNAN         = 32'h7FC00000,
    parameter bit          FLUSH_DENORM = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_cin,
    output logic        res_sign,
    output logic [7:0]  res_exp,
    output logic        eff_sub,
    output logic        special,
    output logic [31:0] special_val
);

    // Stage 1 unpack / compare results (combinational, from the input port)
    logic        sa, sb;
    logic [7:0]  ea, eb, eea, eeb;
    logic [22:0] fa, fb;
    logic [23:0] sig_a, sig_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        a_ge_b, mag_eq;
    logic [23:0] c_sig_l, c_sig_s;
    logic [7:0]  c_exp_l, c_d;
    logic        c_sign, c_eff, c_special;
    logic [31:0] c_sval;

    // Stage 2 alignment results (combinational, from stage-1 registers)
    logic [31:0] field_l, field_s, shifted, mask, al_s;
    logic        sticky;

    // Flow control
    logic adv2;

    // Stage 1 registers
    logic        s1_valid_q, s1_valid_d;
    logic [23:0] s1_sig_l_q, s1_sig_l_d, s1_sig_s_q, s1_sig_s_d;
    logic [7:0]  s1_exp_l_q, s1_exp_l_d, s1_d_q, s1_d_d;
    logic        s1_sign_q, s1_sign_d, s1_eff_q, s1_eff_d;
    logic        s1_special_q, s1_special_d;
    logic [31:0] s1_sval_q, s1_sval_d;

    // Stage 2 (output) registers
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic        op_cin_q, op_cin_d, res_sign_q, res_sign_d;
    logic [7:0]  res_exp_q, res_exp_d;
    logic        eff_sub_q, eff_sub_d, special_q, special_d;
    logic [31:0] special_val_q, special_val_d;

    // Stage 1: unpack operands, classify, order by magnitude, detect specials
    always_comb begin
        sa = in_a[31];
        sb = in_b[31] ^ in_sub;
        ea = in_a[30:23];
        eb = in_b[30:23];
        fa = (FLUSH_DENORM && ea == 8'h00) ? 23'h0 : in_a[22:0];
        fb = (FLUSH_DENORM && eb == 8'h00) ? 23'h0 : in_b[22:0];

        a_nan  = (ea == 8'hFF) && (fa != 23'h0);
        b_nan  = (eb == 8'hFF) && (fb != 23'h0);
        a_inf  = (ea == 8'hFF) && (fa == 23'h0);
        b_inf  = (eb == 8'hFF) && (fb == 23'h0);
        a_zero = (ea == 8'h00) && (fa == 23'h0);
        b_zero = (eb == 8'h00) && (fb == 23'h0);

        // Denormals carry no hidden bit but share the exponent of the smallest normal
        sig_a = {(ea != 8'h00), fa};
        sig_b = {(eb != 8'h00), fb};
        eea   = (ea == 8'h00) ? 8'h01 : ea;
        eeb   = (eb == 8'h00) ? 8'h01 : eb;

        a_ge_b = {ea, fa} >= {eb, fb};
        mag_eq = {ea, fa} == {eb, fb};
        c_eff  = sa ^ sb;

        if (a_ge_b) begin
            c_sig_l = sig_a;
            c_sig_s = sig_b;
            c_exp_l = ea;
            c_d     = eea - eeb;
            c_sign  = sa;
        end else begin
            c_sig_l = sig_b;
            c_sig_s = sig_a;
            c_exp_l = eb;
            c_d     = eeb - eea;
            c_sign  = sb;
        end
        // Exact cancellation always yields +0
        if (c_eff && mag_eq) c_sign = 1'b0;

        c_special = 1'b1;
        if (a_nan || b_nan || (a_inf && b_inf && c_eff)) c_sval = QNAN;
        else if (a_inf)                                  c_sval = {sa, 8'hFF, 23'h0};
        else if (b_inf)                                  c_sval = {sb, 8'hFF, 23'h0};
        else if (a_zero && b_zero)                       c_sval = {(sa & sb), 31'h0};
        else begin
            c_special = 1'b0;
            c_sval    = 32'h0;
        end
    end

    // Stage 2: right-shift the smaller significand with sticky collapse into bit 0
    always_comb begin
        field_l = {1'b0, s1_sig_l_q, 7'b0};
        field_s = {1'b0, s1_sig_s_q, 7'b0};
        shifted = field_s >> s1_d_q[4:0];
        mask    = (32'h1 << s1_d_q[4:0]) - 32'h1;
        sticky  = |(field_s & mask);
        if (s1_d_q >= 8'd31) al_s = {31'h0, (s1_sig_s_q != 24'h0)};
        else                 al_s = shifted | {31'h0, sticky};
    end

    assign adv2     = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | adv2;

    // Next-state: stage 1 loads on input transfer, stage 2 loads whenever it may advance
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sig_l_d    = s1_sig_l_q;
        s1_sig_s_d    = s1_sig_s_q;
        s1_exp_l_d    = s1_exp_l_q;
        s1_d_d        = s1_d_q;
        s1_sign_d     = s1_sign_q;
        s1_eff_d      = s1_eff_q;
        s1_special_d  = s1_special_q;
        s1_sval_d     = s1_sval_q;
        s2_valid_d    = s2_valid_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_cin_d      = op_cin_q;
        res_sign_d    = res_sign_q;
        res_exp_d     = res_exp_q;
        eff_sub_d     = eff_sub_q;
        special_d     = special_q;
        special_val_d = special_val_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sig_l_d   = c_sig_l;
                s1_sig_s_d   = c_sig_s;
                s1_exp_l_d   = c_exp_l;
                s1_d_d       = c_d;
                s1_sign_d    = c_sign;
                s1_eff_d     = c_eff;
                s1_special_d = c_special;
                s1_sval_d    = c_sval;
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                op_a_d        = field_l;
                op_b_d        = s1_eff_q ? ~al_s : al_s;
                op_cin_d      = s1_eff_q;
                res_sign_d    = s1_sign_q;
                res_exp_d     = s1_exp_l_q;
                eff_sub_d     = s1_eff_q;
                special_d     = s1_special_q;
                special_val_d = s1_sval_q;
            end
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sig_l_q    <= 24'h0;
            s1_sig_s_q    <= 24'h0;
            s1_exp_l_q    <= 8'h0;
            s1_d_q        <= 8'h0;
            s1_sign_q     <= 1'b0;
            s1_eff_q      <= 1'b0;
            s1_special_q  <= 1'b0;
            s1_sval_q     <= 32'h0;
            s2_valid_q    <= 1'b0;
            op_a_q        <= 32'h0;
            op_b_q        <= 32'h0;
            op_cin_q      <= 1'b0;
            res_sign_q    <= 1'b0;
            res_exp_q     <= 8'h0;
            eff_sub_q     <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= 32'h0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sig_l_q    <= s1_sig_l_d;
            s1_sig_s_q    <= s1_sig_s_d;
            s1_exp_l_q    <= s1_exp_l_d;
            s1_d_q        <= s1_d_d;
            s1_sign_q     <= s1_sign_d;
            s1_eff_q      <= s1_eff_d;
            s1_special_q  <= s1_special_d;
            s1_sval_q     <= s1_sval_d;
            s2_valid_q    <= s2_valid_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_cin_q      <= op_cin_d;
            res_sign_q    <= res_sign_d;
            res_exp_q     <= res_exp_d;
            eff_sub_q     <= eff_sub_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_cin      = op_cin_q;
    assign res_sign    = res_sign_q;
    assign res_exp     = res_exp_q;
    assign eff_sub     = eff_sub_q;
    assign special     = special_q;
    assign special_val = special_val_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: hand-computed alignment vectors, specials,
// backpressure and mid-stream reset.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a, op_b;
    logic        op_cin, res_sign, eff_sub, special;
    logic [7:0]  res_exp;
    logic [31:0] special_val;

    int n_tests = 0;
    int n_fail  = 0;

    fp_align_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_cin     (op_cin),
        .res_sign   (res_sign),
        .res_exp    (res_exp),
        .eff_sub    (eff_sub),
        .special    (special),
        .special_val(special_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operand pair with the pipeline otherwise empty, check 2-cycle latency
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        chk("send_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_not_yet", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("lat_valid", {31'h0, out_valid}, 32'h1);
    endtask

    task automatic chk_path(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic ecin, input logic [7:0] eexp, input logic esign,
                            input logic espec);
        chk({tag, "_op_a"},   op_a, ea);
        chk({tag, "_op_b"},   op_b, eb);
        chk({tag, "_cin"},    {31'h0, op_cin}, {31'h0, ecin});
        chk({tag, "_effsub"}, {31'h0, eff_sub}, {31'h0, ecin});
        chk({tag, "_exp"},    {24'h0, res_exp}, {24'h0, eexp});
        chk({tag, "_sign"},   {31'h0, res_sign}, {31'h0, esign});
        chk({tag, "_special"},{31'h0, special}, {31'h0, espec});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_special_val", special_val, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // 1.0 + 1.0
        send(32'h3F800000, 32'h3F800000, 1'b0);
        chk_path("t1", 32'h40000000, 32'h40000000, 1'b0, 8'h7F, 1'b0, 1'b0);
        // 1.0 - 0.5
        send(32'h3F800000, 32'h3F000000, 1'b1);
        chk_path("t2", 32'h40000000, 32'hDFFFFFFF, 1'b1, 8'h7F, 1'b0, 1'b0);
        // 0.5 + 2.0 swaps operands
        send(32'h3F000000, 32'h40000000, 1'b0);
        chk_path("t3a", 32'h40000000, 32'h10000000, 1'b0, 8'h80, 1'b0, 1'b0);
        // huge exponent gap: sticky only
        send(32'h3F800000, 32'h00800000, 1'b0);
        chk_path("t3b", 32'h40000000, 32'h00000001, 1'b0, 8'h7F, 1'b0, 1'b0);
        // d=9 with nonzero shifted-out bit
        send(32'h3F800000, 32'h3B000001, 1'b0);
        chk_path("sticky", 32'h40000000, 32'h00200001, 1'b0, 8'h7F, 1'b0, 1'b0);
        // 1.0 - 2.0: B larger, negative result
        send(32'h3F800000, 32'h40000000, 1'b1);
        chk_path("neg", 32'h40000000, 32'hDFFFFFFF, 1'b1, 8'h80, 1'b1, 1'b0);
        // 1.0 + -1.0 exact cancel
        send(32'h3F800000, 32'hBF800000, 1'b0);
        chk_path("t4a", 32'h40000000, 32'hBFFFFFFF, 1'b1, 8'h7F, 1'b0, 1'b0);
        // +Inf + -Inf
        send(32'h7F800000, 32'hFF800000, 1'b0);
        chk("t4b_special", {31'h0, special}, 32'h1);
        chk("t4b_val", special_val, 32'h7FC00000);
        // Inf + 1
        send(32'h7F800000, 32'h3F800000, 1'b0);
        chk("t5a_special", {31'h0, special}, 32'h1);
        chk("t5a_val", special_val, 32'h7F800000);
        // 1 - (+Inf) -> -Inf
        send(32'h3F800000, 32'h7F800000, 1'b1);
        chk("binf_val", special_val, 32'hFF800000);
        // NaN input
        send(32'h7FC00001, 32'h3F800000, 1'b0);
        chk("t5b_val", special_val, 32'h7FC00000);
        // -0 + -0
        send(32'h80000000, 32'h80000000, 1'b0);
        chk("t5c_special", {31'h0, special}, 32'h1);
        chk("t5c_val", special_val, 32'h80000000);
        // +0 - +0 -> +0
        send(32'h00000000, 32'h00000000, 1'b1);
        chk("zsub_special", {31'h0, special}, 32'h1);
        chk("zsub_val", special_val, 32'h00000000);

        // Backpressure: three back-to-back with out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0; in_valid = 1'b1;
        chk("bp_rdy0", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h3F000000; in_sub = 1'b1;
        chk("bp_rdy1", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_a = 32'h3F000000; in_b = 32'h40000000; in_sub = 1'b0;
        chk("bp_rdy2", {31'h0, in_ready}, 32'h0);
        chk("bp_ov2", {31'h0, out_valid}, 32'h1);
        chk("bp_item0", op_b, 32'h40000000);
        @(negedge clk);
        chk("bp_rdy3", {31'h0, in_ready}, 32'h0);
        chk("bp_frozen", op_b, 32'h40000000);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain_ov1", {31'h0, out_valid}, 32'h1);
        chk("drain_item1", op_b, 32'hDFFFFFFF);
        @(negedge clk);
        chk("drain_ov2", {31'h0, out_valid}, 32'h1);
        chk("drain_item2", op_b, 32'h10000000);
        chk("drain_item2_exp", {24'h0, res_exp}, 32'h80);
        @(negedge clk);
        chk("drain_empty", {31'h0, out_valid}, 32'h0);

        // Mid-stream reset with both stages full
        out_ready = 1'b0;
        in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_ov", {31'h0, out_valid}, 32'h1);
        chk("pre_rst_rdy", {31'h0, in_ready}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ov", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_rdy", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_op_a", op_a, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", {31'h0, out_valid}, 32'h0);

        // Pipeline works again after reset
        send(32'h3F800000, 32'h3F000000, 1'b1);
        chk_path("post_rst", 32'h40000000, 32'hDFFFFFFF, 1'b1, 8'h7F, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
